// File: rtl/puf_pkg.sv
// Shared types and elaboration helpers for the arbiter-PUF CRP sequencer.
package puf_pkg;

  localparam int C_LENGTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    EMIT,
    DONE
  } state_t;

  function automatic int vote_cnt_width(input int votes);
    return $clog2(votes + 1);
  endfunction

  function automatic bit votes_legal(input int votes);
    return (votes >= 1) && ((votes % 2) == 1);
  endfunction

  function automatic bit settle_legal(input int settle);
    return settle >= 1;
  endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// Per-bit launch vote counter producing the majority decision and an unanimity flag.
module puf_vote_counter
  import puf_pkg::*;
#(
  parameter int VOTES = 5
) (
  input  logic iclk,
  input  logic irst,
  input  logic clear,
  input  logic inc,
  input  logic sample,
  output logic majority,
  output logic unstable
);

  localparam int CW = vote_cnt_width(VOTES);
  localparam logic [CW-1:0] HALF = CW'(VOTES / 2);
  localparam logic [CW-1:0] ALL  = CW'(VOTES);

  logic [CW-1:0] count;

  always_ff @(posedge iclk) begin
    if (irst || clear) begin
      count <= '0;
    end else if (inc && sample) begin
      count <= count + CW'(1);
    end
  end

  assign majority = (count > HALF);
  assign unstable = (count != '0) && (count != ALL);

endmodule

// File: rtl/puf_crp_sequencer.sv
// Launches each challenge VOTES times into the arbiter PUF bank and streams
// out majority-voted challenge-response pairs with per-bit instability flags.
module puf_crp_sequencer
  import puf_pkg::*;
#(
  parameter int C_LENGTH      = C_LENGTH_DEF,
  parameter int R_WIDTH       = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int VOTES         = 5
) (
  input  logic                iclk,
  input  logic                irst,
  input  logic                istart,
  input  logic [C_LENGTH-1:0] iseed,
  input  logic [7:0]          icount,
  output logic [C_LENGTH-1:0] ochallenge,
  output logic                opulse,
  input  logic [R_WIDTH-1:0]  iresponse,
  output logic                oresp_valid,
  input  logic                iresp_ready,
  output logic [C_LENGTH-1:0] oresp_chal,
  output logic [R_WIDTH-1:0]  oresp_data,
  output logic [R_WIDTH-1:0]  ounstable,
  output logic                obusy,
  output logic                odone
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LW = (VOTES > 1) ? $clog2(VOTES) : 1;
  localparam logic [SW-1:0] PHASE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [LW-1:0] LAUNCH_LAST = LW'(VOTES - 1);

  if (!settle_legal(SETTLE_CYCLES)) begin : g_bad_settle
    $error("puf_crp_sequencer: SETTLE_CYCLES must be at least 1");
  end
  if (!votes_legal(VOTES)) begin : g_bad_votes
    $error("puf_crp_sequencer: VOTES must be odd and at least 1");
  end

  state_t        state;
  logic [SW-1:0] phase;
  logic [LW-1:0] launch_idx;
  logic [7:0]    remaining;

  logic               vote_clear;
  logic               vote_inc;
  logic [R_WIDTH-1:0] maj_vec;
  logic [R_WIDTH-1:0] unst_vec;

  // The response is captured once per launch, just before the pulse falls,
  // so the arbiters have had the full settle window to resolve.
  assign vote_clear = (state == SETUP);
  assign vote_inc   = (state == HIGH) && (phase == PHASE_LAST);

  for (genvar i = 0; i < R_WIDTH; i++) begin : g_vote
    puf_vote_counter #(.VOTES(VOTES)) u_vote (
      .iclk     (iclk),
      .irst     (irst),
      .clear    (vote_clear),
      .inc      (vote_inc),
      .sample   (iresponse[i]),
      .majority (maj_vec[i]),
      .unstable (unst_vec[i])
    );
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state       <= IDLE;
      phase       <= '0;
      launch_idx  <= '0;
      remaining   <= '0;
      ochallenge  <= '0;
      opulse      <= 1'b0;
      oresp_valid <= 1'b0;
      oresp_chal  <= '0;
      oresp_data  <= '0;
      ounstable   <= '0;
      obusy       <= 1'b0;
      odone       <= 1'b0;
    end else begin
      odone <= 1'b0;
      case (state)
        IDLE: begin
          if (istart) begin
            obusy <= 1'b1;
            if (icount != 8'd0) begin
              ochallenge <= iseed;
              remaining  <= icount;
              state      <= SETUP;
            end else begin
              odone <= 1'b1;
              state <= DONE;
            end
          end
        end
        SETUP: begin
          phase      <= '0;
          launch_idx <= '0;
          opulse     <= 1'b1;
          state      <= HIGH;
        end
        HIGH: begin
          if (phase == PHASE_LAST) begin
            phase  <= '0;
            opulse <= 1'b0;
            state  <= LOW;
          end else begin
            phase <= phase + SW'(1);
          end
        end
        LOW: begin
          if (phase == PHASE_LAST) begin
            phase <= '0;
            if (launch_idx != LAUNCH_LAST) begin
              launch_idx <= launch_idx + LW'(1);
              opulse     <= 1'b1;
              state      <= HIGH;
            end else begin
              oresp_valid <= 1'b1;
              oresp_chal  <= ochallenge;
              oresp_data  <= maj_vec;
              ounstable   <= unst_vec;
              state       <= EMIT;
            end
          end else begin
            phase <= phase + SW'(1);
          end
        end
        EMIT: begin
          if (iresp_ready) begin
            oresp_valid <= 1'b0;
            if (remaining > 8'd1) begin
              remaining  <= remaining - 8'd1;
              ochallenge <= ochallenge + C_LENGTH'(1);
              state      <= SETUP;
            end else begin
              odone <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          obusy <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Directed bench for puf_crp_sequencer with a behavioural PUF bank model.
module tb_puf_crp_sequencer;

  logic       iclk = 1'b0;
  logic       irst;
  logic       istart;
  logic [7:0] iseed;
  logic [7:0] icount;
  logic [7:0] ochallenge;
  logic       opulse;
  logic [7:0] iresponse = '0;
  logic       oresp_valid;
  logic       iresp_ready;
  logic [7:0] oresp_chal;
  logic [7:0] oresp_data;
  logic [7:0] ounstable;
  logic       obusy;
  logic       odone;

  int n_checks = 0;
  int n_fail   = 0;

  int         launch_cnt = 0;
  bit         flaky_en   = 1'b0;
  logic [4:0] flaky_seq  = '0;

  always #5 iclk = ~iclk;

  puf_crp_sequencer dut (
    .iclk        (iclk),
    .irst        (irst),
    .istart      (istart),
    .iseed       (iseed),
    .icount      (icount),
    .ochallenge  (ochallenge),
    .opulse      (opulse),
    .iresponse   (iresponse),
    .oresp_valid (oresp_valid),
    .iresp_ready (iresp_ready),
    .oresp_chal  (oresp_chal),
    .oresp_data  (oresp_data),
    .ounstable   (ounstable),
    .obusy       (obusy),
    .odone       (odone)
  );

  // PUF bank: a fixed response per challenge, with bit 0 optionally following a per-launch pattern.
  always @(posedge opulse) begin
    iresponse = ochallenge ^ 8'hA5;
    if (flaky_en) iresponse[0] = flaky_seq[launch_cnt % 5];
    launch_cnt = launch_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] seed, input logic [7:0] count);
    istart = 1'b1;
    iseed  = seed;
    icount = count;
    @(negedge iclk);
    istart = 1'b0;
    iseed  = '0;
    icount = '0;
  endtask

  task automatic waitForBeat(input string tag, input int exp_lat, input bit chk_lat);
    int cycles = 0;
    while (!oresp_valid && cycles < 200) begin
      @(negedge iclk);
      cycles++;
    end
    checkOutput({tag, "_valid"}, 32'(oresp_valid), 32'd1);
    if (chk_lat) checkOutput({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
  endtask

  task automatic checkBeat(input string tag, input logic [7:0] chal,
                           input logic [7:0] data, input logic [7:0] unst);
    checkOutput({tag, "_chal"}, 32'(oresp_chal), 32'(chal));
    checkOutput({tag, "_data"}, 32'(oresp_data), 32'(data));
    checkOutput({tag, "_unstable"}, 32'(ounstable), 32'(unst));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] chal;
    int         launches_before;
    bit         any_valid;

    irst        = 1'b1;
    istart      = 1'b0;
    iseed       = '0;
    icount      = '0;
    iresp_ready = 1'b1;
    repeat (3) @(negedge iclk);
    checkOutput("rst_challenge", 32'(ochallenge), 32'd0);
    checkOutput("rst_pulse", 32'(opulse), 32'd0);
    checkOutput("rst_valid", 32'(oresp_valid), 32'd0);
    checkOutput("rst_data", 32'(oresp_data), 32'd0);
    checkOutput("rst_unstable", 32'(ounstable), 32'd0);
    checkOutput("rst_busy", 32'(obusy), 32'd0);
    checkOutput("rst_done", 32'(odone), 32'd0);
    irst = 1'b0;
    @(negedge iclk);

    $display("[TB] stable PUF, three beats from 0x10");
    applyStimulus(8'h10, 8'd3);
    for (int b = 0; b < 3; b++) begin
      chal = 8'h10 + 8'(b);
      waitForBeat($sformatf("t1_b%0d", b), 41, 1'b1);
      checkBeat($sformatf("t1_b%0d", b), chal, chal ^ 8'hA5, 8'h00);
      checkOutput("t1_busy_run", 32'(obusy), 32'd1);
      @(negedge iclk);
    end
    checkOutput("t1_done_pulse", 32'(odone), 32'd1);
    checkOutput("t1_busy_done", 32'(obusy), 32'd1);
    @(negedge iclk);
    checkOutput("t1_done_drop", 32'(odone), 32'd0);
    checkOutput("t1_busy_drop", 32'(obusy), 32'd0);

    $display("[TB] flaky bit 0, pattern 1,0,1,0,1");
    flaky_en  = 1'b1;
    flaky_seq = 5'b10101;
    applyStimulus(8'h20, 8'd1);
    waitForBeat("t2", 41, 1'b1);
    checkBeat("t2", 8'h20, 8'h85, 8'h01);
    @(negedge iclk);
    checkOutput("t2_done", 32'(odone), 32'd1);
    @(negedge iclk);

    $display("[TB] flaky bit 0, pattern 0,0,1,0,0");
    flaky_seq = 5'b00100;
    applyStimulus(8'h20, 8'd1);
    waitForBeat("t3", 41, 1'b1);
    checkBeat("t3", 8'h20, 8'h84, 8'h01);
    @(negedge iclk);
    @(negedge iclk);
    flaky_en = 1'b0;

    $display("[TB] backpressure during EMIT");
    iresp_ready = 1'b0;
    applyStimulus(8'h30, 8'd1);
    waitForBeat("t4", 41, 1'b1);
    checkBeat("t4", 8'h30, 8'h95, 8'h00);
    launches_before = launch_cnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge iclk);
      checkOutput("t4_hold_pulse", 32'(opulse), 32'd0);
      checkOutput("t4_hold_valid", 32'(oresp_valid), 32'd1);
      checkBeat("t4_hold", 8'h30, 8'h95, 8'h00);
    end
    iresp_ready = 1'b1;
    @(negedge iclk);
    checkOutput("t4_accept_valid", 32'(oresp_valid), 32'd0);
    checkOutput("t4_accept_done", 32'(odone), 32'd1);
    checkOutput("t4_launches", 32'(launch_cnt), 32'(launches_before));
    @(negedge iclk);

    $display("[TB] wrap from 0xFF with ignored istart mid-run");
    applyStimulus(8'hFF, 8'd2);
    repeat (5) @(negedge iclk);
    istart = 1'b1;
    iseed  = 8'h55;
    icount = 8'd9;
    @(negedge iclk);
    istart = 1'b0;
    iseed  = '0;
    icount = '0;
    waitForBeat("t5_b0", 0, 1'b0);
    checkBeat("t5_b0", 8'hFF, 8'h5A, 8'h00);
    @(negedge iclk);
    waitForBeat("t5_b1", 41, 1'b1);
    checkBeat("t5_b1", 8'h00, 8'hA5, 8'h00);
    @(negedge iclk);
    checkOutput("t5_done", 32'(odone), 32'd1);
    @(negedge iclk);
    checkOutput("t5_idle_busy", 32'(obusy), 32'd0);

    $display("[TB] empty run");
    applyStimulus(8'h77, 8'd0);
    checkOutput("t6_done", 32'(odone), 32'd1);
    checkOutput("t6_busy", 32'(obusy), 32'd1);
    any_valid = oresp_valid;
    for (int c = 0; c < 50; c++) begin
      @(negedge iclk);
      if (oresp_valid) any_valid = 1'b1;
    end
    checkOutput("t6_no_valid", 32'(any_valid), 32'd0);
    checkOutput("t6_idle_busy", 32'(obusy), 32'd0);

    $display("[TB] reset in second HIGH cycle");
    applyStimulus(8'h40, 8'd2);
    @(negedge iclk);
    @(negedge iclk);
    checkOutput("t7_pulse_high", 32'(opulse), 32'd1);
    irst = 1'b1;
    @(negedge iclk);
    checkOutput("t7_pulse_reset", 32'(opulse), 32'd0);
    checkOutput("t7_busy_reset", 32'(obusy), 32'd0);
    checkOutput("t7_valid_reset", 32'(oresp_valid), 32'd0);
    checkOutput("t7_chal_reset", 32'(ochallenge), 32'd0);
    irst = 1'b0;
    @(negedge iclk);
    applyStimulus(8'h40, 8'd1);
    waitForBeat("t7_restart", 41, 1'b1);
    checkBeat("t7_restart", 8'h40, 8'hE5, 8'h00);
    @(negedge iclk);
    @(negedge iclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
